// File: rtl/rv_issue_scoreboard.sv
// In-order issue controller with per-register pending scoreboard, LAT-deep writeback pipe and issue/stall stats.
// Optional macro RV_SB_WB_BYPASS_EN: hazard check ignores the register currently in WB (WB->ID forwarding).
module rv_issue_scoreboard #(
    parameter int unsigned LAT   = 3,
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 32,
    localparam int unsigned RW   = $clog2(NREG),
    localparam int unsigned IW   = $clog2(LAT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RW-1:0]    in_rd,
    input  logic [RW-1:0]    in_rs1,
    input  logic [RW-1:0]    in_rs2,
    input  logic             in_use_rs1,
    input  logic             in_use_rs2,
    input  logic             in_wr_rd,
    input  logic             flush,
    output logic             issue_valid,
    output logic [RW-1:0]    issue_rd,
    output logic             wb_valid,
    output logic [RW-1:0]    wb_rd,
    output logic [NREG-1:0]  busy_mask,
    output logic [IW-1:0]    inflight,
    output logic [CNT_W-1:0] issue_count,
    output logic [CNT_W-1:0] stall_count
);

    logic [NREG-1:0]  pending_q, pending_d;
    logic [LAT-1:0]   pipe_v_q, pipe_v_d;
    logic [LAT-1:0]   pipe_w_q, pipe_w_d;
    logic [RW-1:0]    pipe_rd_q [LAT];
    logic [RW-1:0]    pipe_rd_d [LAT];
    logic [IW-1:0]    inflight_q, inflight_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic             wb_v_c;
    logic [RW-1:0]    wb_rd_c;
    logic [NREG-1:0]  pend_eff_c;
    logic             raw_c;
    logic             waw_c;
    logic             hs_c;
    logic             new_w_c;

    // The last pipe stage is the WB cycle; w already implies v and rd != x0.
    assign wb_v_c  = pipe_w_q[LAT-1];
    assign wb_rd_c = pipe_rd_q[LAT-1];

    // Hazard detection against the scoreboard.
    always_comb begin
        pend_eff_c = pending_q;
`ifdef RV_SB_WB_BYPASS_EN
        if (wb_v_c) begin
            pend_eff_c[wb_rd_c] = 1'b0;
        end
`endif
        raw_c = (in_use_rs1 && (in_rs1 != '0) && pend_eff_c[in_rs1]) ||
                (in_use_rs2 && (in_rs2 != '0) && pend_eff_c[in_rs2]);
        waw_c = in_wr_rd && (in_rd != '0) && pend_eff_c[in_rd];
    end

    assign in_ready = !(raw_c || waw_c || flush);
    assign hs_c     = in_valid && in_ready;
    assign new_w_c  = in_wr_rd && (in_rd != '0);

    // Pipe shift, scoreboard update (set after clear so a same-edge set wins), flush kill.
    always_comb begin
        pending_d    = pending_q;
        pipe_v_d     = pipe_v_q << 1;
        pipe_w_d     = pipe_w_q << 1;
        pipe_rd_d[0] = '0;
        for (int k = 1; k < int'(LAT); k++) begin
            pipe_rd_d[k] = pipe_rd_q[k-1];
        end

        if (wb_v_c) begin
            pending_d[wb_rd_c] = 1'b0;
        end

        if (hs_c) begin
            pipe_v_d[0]  = 1'b1;
            pipe_w_d[0]  = new_w_c;
            pipe_rd_d[0] = in_rd;
            if (new_w_c) begin
                pending_d[in_rd] = 1'b1;
            end
        end

        if (flush) begin
            pending_d = '0;
            pipe_v_d  = '0;
            pipe_w_d  = '0;
        end
    end

    // Occupancy and statistics.
    always_comb begin
        inflight_d = '0;
        for (int k = 0; k < int'(LAT); k++) begin
            inflight_d = inflight_d + IW'(pipe_v_d[k]);
        end
        issue_cnt_d = issue_cnt_q + (hs_c ? CNT_W'(1) : CNT_W'(0));
        stall_cnt_d = stall_cnt_q +
                      ((in_valid && !in_ready && !flush) ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= '0;
            pipe_v_q    <= '0;
            pipe_w_q    <= '0;
            inflight_q  <= '0;
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
            for (int k = 0; k < int'(LAT); k++) begin
                pipe_rd_q[k] <= '0;
            end
        end else begin
            pending_q   <= pending_d;
            pipe_v_q    <= pipe_v_d;
            pipe_w_q    <= pipe_w_d;
            inflight_q  <= inflight_d;
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            for (int k = 0; k < int'(LAT); k++) begin
                pipe_rd_q[k] <= pipe_rd_d[k];
            end
        end
    end

    assign issue_valid = pipe_v_q[0];
    assign issue_rd    = pipe_rd_q[0];
    assign wb_valid    = wb_v_c;
    assign wb_rd       = wb_v_c ? wb_rd_c : '0;
    assign busy_mask   = pending_q;
    assign inflight    = inflight_q;
    assign issue_count = issue_cnt_q;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_rv_issue_scoreboard.sv
// Directed self-checking bench for rv_issue_scoreboard at LAT=3, NREG=32.
module tb_rv_issue_scoreboard;

    localparam int unsigned LAT   = 3;
    localparam int unsigned NREG  = 32;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned RW    = 5;
    localparam int unsigned IW    = 2;
`ifdef RV_SB_WB_BYPASS_EN
    localparam int STALL = 2;
`else
    localparam int STALL = 3;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [RW-1:0]    in_rd, in_rs1, in_rs2;
    logic             in_use_rs1, in_use_rs2, in_wr_rd;
    logic             flush;
    logic             issue_valid;
    logic [RW-1:0]    issue_rd;
    logic             wb_valid;
    logic [RW-1:0]    wb_rd;
    logic [NREG-1:0]  busy_mask;
    logic [IW-1:0]    inflight;
    logic [CNT_W-1:0] issue_count, stall_count;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] exp_issue;
    logic [CNT_W-1:0] exp_stall;

    rv_issue_scoreboard #(.LAT(LAT), .NREG(NREG), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_wr_rd(in_wr_rd),
        .flush(flush),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .busy_mask(busy_mask), .inflight(inflight),
        .issue_count(issue_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_use_rs1 = 1'b0; in_use_rs2 = 1'b0; in_wr_rd = 1'b0; flush = 1'b0;
    endtask

    task automatic drive(input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                         input logic [RW-1:0] rs2, input logic u1, input logic u2,
                         input logic wr);
        in_valid = 1'b1; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_use_rs1 = u1; in_use_rs2 = u2; in_wr_rd = wr;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        exp_issue = '0;
        exp_stall = '0;
        checks++;
        if ({issue_valid, issue_rd, wb_valid, wb_rd, busy_mask, inflight, issue_count, stall_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: iv=%0b ird=%0d wv=%0b wrd=%0d busy=%h infl=%0d ic=%0d sc=%0d, want all 0",
                     issue_valid, issue_rd, wb_valid, wb_rd, busy_mask, inflight, issue_count, stall_count);
        end
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [IW-1:0] e_infl;
        logic          e_wv;
        logic [RW-1:0] e_wrd;
        for (int i = 0; i < 4; i++) begin
            drive(RW'(i + 1), '0, '0, 1'b0, 1'b0, 1'b1);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %0b want 1", i, in_ready); end
            exp_issue++;
            tick();
            idle();
            checks++;
            if (issue_valid !== 1'b1 || issue_rd !== RW'(i + 1)) begin
                errors++;
                $display("FAIL b2b_issue[%0d]: got v=%0b rd=%0d want v=1 rd=%0d", i, issue_valid, issue_rd, i + 1);
            end
            e_infl = (i + 1 > 3) ? IW'(3) : IW'(i + 1);
            checks++;
            if (inflight !== e_infl) begin errors++; $display("FAIL b2b_inflight[%0d]: got %0d want %0d", i, inflight, e_infl); end
            e_wv  = (i >= 2);
            e_wrd = (i >= 2) ? RW'(i - 1) : RW'(0);
            checks++;
            if (wb_valid !== e_wv || (e_wv && wb_rd !== e_wrd)) begin
                errors++;
                $display("FAIL b2b_wb[%0d]: got v=%0b rd=%0d want v=%0b rd=%0d", i, wb_valid, wb_rd, e_wv, e_wrd);
            end
        end
        checks++;
        if (busy_mask !== 32'h0000_001C) begin errors++; $display("FAIL b2b_busy: got %h want 0000001c", busy_mask); end
        for (int j = 0; j < 3; j++) begin
            tick();
            e_wv  = (j < 2);
            e_wrd = RW'(3 + j);
            checks++;
            if (wb_valid !== e_wv || (e_wv && wb_rd !== e_wrd)) begin
                errors++;
                $display("FAIL b2b_drain_wb[%0d]: got v=%0b rd=%0d want v=%0b rd=%0d", j, wb_valid, wb_rd, e_wv, e_wrd);
            end
        end
        checks++;
        if (inflight !== '0 || busy_mask !== '0) begin
            errors++; $display("FAIL b2b_idle: got infl=%0d busy=%h want 0 0", inflight, busy_mask);
        end
        checks++;
        if (issue_count !== exp_issue || stall_count !== exp_stall) begin
            errors++; $display("FAIL b2b_counts: got ic=%0d sc=%0d want %0d %0d", issue_count, stall_count, exp_issue, exp_stall);
        end
    endtask

    task automatic test_raw();
        logic e_wv;
        drive(5'd5, '0, '0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_first_ready: got %0b want 1", in_ready); end
        exp_issue++;
        tick();
        drive(5'd6, 5'd5, '0, 1'b1, 1'b0, 1'b1);
        for (int j = 0; j < STALL; j++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall[%0d]: got ready=%0b want 0", j, in_ready); end
            exp_stall++;
            tick();
        end
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_release: got ready=%0b want 1", in_ready); end
        e_wv = (STALL == 2);
        checks++;
        if (wb_valid !== e_wv || (e_wv && wb_rd !== 5'd5)) begin
            errors++; $display("FAIL raw_release_wb: got v=%0b rd=%0d want v=%0b rd=5", wb_valid, wb_rd, e_wv);
        end
        exp_issue++;
        tick();
        idle();
        checks++;
        if (issue_valid !== 1'b1 || issue_rd !== 5'd6) begin
            errors++; $display("FAIL raw_issue: got v=%0b rd=%0d want v=1 rd=6", issue_valid, issue_rd);
        end
        checks++;
        if (busy_mask !== 32'h0000_0040) begin errors++; $display("FAIL raw_busy: got %h want 00000040", busy_mask); end
        checks++;
        if (stall_count !== exp_stall || issue_count !== exp_issue) begin
            errors++; $display("FAIL raw_counts: got ic=%0d sc=%0d want %0d %0d", issue_count, stall_count, exp_issue, exp_stall);
        end
        repeat (4) tick();
        checks++;
        if (busy_mask !== '0 || inflight !== '0) begin
            errors++; $display("FAIL raw_drain: got busy=%h infl=%0d want 0 0", busy_mask, inflight);
        end
    endtask

    task automatic test_x0();
        drive('0, '0, '0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL x0_ready_a: got %0b want 1", in_ready); end
        exp_issue++;
        tick();
        drive('0, '0, '0, 1'b1, 1'b0, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL x0_ready_b: got %0b want 1", in_ready); end
        exp_issue++;
        tick();
        idle();
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (wb_valid !== 1'b0 || busy_mask !== '0) begin
                errors++; $display("FAIL x0_quiet[%0d]: got wv=%0b busy=%h want 0 0", j, wb_valid, busy_mask);
            end
            tick();
        end
        checks++;
        if (issue_count !== exp_issue || stall_count !== exp_stall) begin
            errors++; $display("FAIL x0_counts: got ic=%0d sc=%0d want %0d %0d", issue_count, stall_count, exp_issue, exp_stall);
        end
    endtask

    task automatic test_waw();
        drive(5'd7, '0, '0, 1'b0, 1'b0, 1'b1);
        exp_issue++;
        tick();
        drive(5'd7, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < STALL; j++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || busy_mask !== 32'h0000_0080) begin
                errors++; $display("FAIL waw_stall[%0d]: got ready=%0b busy=%h want 0 00000080", j, in_ready, busy_mask);
            end
            exp_stall++;
            tick();
        end
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL waw_release: got %0b want 1", in_ready); end
        exp_issue++;
        tick();
        idle();
        checks++;
        if (busy_mask !== 32'h0000_0080 || issue_rd !== 5'd7) begin
            errors++; $display("FAIL waw_after: got busy=%h ird=%0d want 00000080 7", busy_mask, issue_rd);
        end
        repeat (4) tick();
        checks++;
        if (busy_mask !== '0 || stall_count !== exp_stall || issue_count !== exp_issue) begin
            errors++; $display("FAIL waw_drain: got busy=%h sc=%0d ic=%0d want 0 %0d %0d",
                               busy_mask, stall_count, issue_count, exp_stall, exp_issue);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(RW'(8 + i), '0, '0, 1'b0, 1'b0, 1'b1);
            exp_issue++;
            tick();
        end
        idle();
        checks++;
        if (inflight !== IW'(3) || busy_mask !== 32'h0000_0700) begin
            errors++; $display("FAIL flush_pre: got infl=%0d busy=%h want 3 00000700", inflight, busy_mask);
        end
        drive(5'd11, '0, '0, 1'b0, 1'b0, 1'b1);
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %0b want 0", in_ready); end
        tick();
        idle();
        checks++;
        if (busy_mask !== '0 || inflight !== '0 || issue_valid !== 1'b0 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL flush_clear: got busy=%h infl=%0d iv=%0b wv=%0b want 0 0 0 0",
                               busy_mask, inflight, issue_valid, wb_valid);
        end
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_rearm: got %0b want 1", in_ready); end
        checks++;
        if (issue_count !== exp_issue || stall_count !== exp_stall) begin
            errors++; $display("FAIL flush_counts: got ic=%0d sc=%0d want %0d %0d", issue_count, stall_count, exp_issue, exp_stall);
        end
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++;
            if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_no_wb[%0d]: got wv=%0b rd=%0d want 0", j, wb_valid, wb_rd); end
        end
    endtask

    task automatic test_rst_mid();
        drive(5'd12, '0, '0, 1'b0, 1'b0, 1'b1);
        exp_issue++;
        tick();
        drive(5'd13, 5'd12, '0, 1'b1, 1'b0, 1'b1);
        #1;
        exp_stall++;
        tick();
        checks++;
        if (issue_count !== exp_issue || stall_count !== exp_stall) begin
            errors++; $display("FAIL rst_pre_counts: got ic=%0d sc=%0d want %0d %0d", issue_count, stall_count, exp_issue, exp_stall);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        exp_issue = '0;
        exp_stall = '0;
        checks++;
        if ({issue_valid, issue_rd, wb_valid, wb_rd, busy_mask, inflight, issue_count, stall_count} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: iv=%0b ird=%0d wv=%0b wrd=%0d busy=%h infl=%0d ic=%0d sc=%0d, want all 0",
                     issue_valid, issue_rd, wb_valid, wb_rd, busy_mask, inflight, issue_count, stall_count);
        end
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %0b want 1", in_ready); end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        exp_issue = '0;
        exp_stall = '0;
        test_reset();
        test_back_to_back();
        test_raw();
        test_x0();
        test_waw();
        test_flush();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
